bitwise_logic_seq: RTL and testbench

Parametrised, multi-cycle bitwise logic unit for the processor datapath, generalising the fixed 32-bit inverter to eight bitwise operations over a configurable word width. Operands are latched on a start pulse and processed one SLICE-bit chunk per clock, trading latency for area. Completion is signalled by a one-cycle done pulse, with a registered result and zero flag. It sits beside the adder/shifter inside the ALU and is sequenced by the multi-cycle control unit.

---
 rtl/alu_logic_pkg.sv | 26 ++
 rtl/logic_slice.sv | 35 +++
 rtl/bitwise_logic_seq.sv | 178 +++++++++++++++++
 tb/tb_bitwise_logic_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_logic_pkg.sv
// ---------------------------------------------------------------------------
// alu_logic_pkg
//   Shared definitions for the multi-cycle bitwise logic unit.
//   - OP_W / OP_*   : operation select width and op-code values
//   - state_t       : control FSM state encoding, also driven out on the
//                     unit's debug port so checkers can follow the sequencing
// ---------------------------------------------------------------------------
package alu_logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
  localparam logic [OP_W-1:0] OP_AND  = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_NAND = 3'b101;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// ---------------------------------------------------------------------------
// logic_slice
//   Combinational SLICE-bit bitwise operation unit.
//   Ports:
//     a, b : SLICE-bit operands (b ignored by NOT and PASS)
//     op   : operation select (OP_NOT .. OP_PASS)
//     y    : SLICE-bit result
// ---------------------------------------------------------------------------
module logic_slice
  import alu_logic_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_seq.sv
// ---------------------------------------------------------------------------
// bitwise_logic_seq
//   Multi-cycle bitwise logic unit. Operands and op are latched on an
//   accepted start and one SLICE-bit chunk is computed per clock through a
//   single shared logic_slice. After NSLICE cycles the assembled word is
//   loaded into result/zero and done pulses for one cycle.
//
//   Handshake: start is a request sampled only while busy=0 (IDLE); a start
//   seen in IDLE on a rising edge is accepted on that edge, anything on start
//   while busy=1 is ignored. Each accepted start yields exactly one done
//   pulse unless reset intervenes. Holding start high chains operations.
//
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     start      : operation request (IDLE only)
//     op, a, b   : operation select and operands, sampled with start
//     busy       : operation in progress
//     done       : one-cycle completion pulse
//     result     : registered result, holds between operations
//     zero       : registered result == 0 flag
//     dbg_state  : current control FSM state (debug visibility)
// ---------------------------------------------------------------------------
module bitwise_logic_seq
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output state_t           dbg_state
);

  localparam int NSLICE = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Reject geometries that cannot be cut into whole slices.
  if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_geometry
    $fatal(1, "bitwise_logic_seq: WIDTH must be a positive multiple of SLICE");
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic [WIDTH-1:0]  result_q;
  logic              zero_q;
  logic              done_q;

  logic              accept;
  logic              step;
  logic              finish;
  logic              last_slice;

  logic [SLICE-1:0]  a_sel, b_sel, y_slice;
  logic [WIDTH-1:0]  acc_full;  // accumulator with the current slice merged in

  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  // ---------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Control FSM: next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_slice) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Slice selection and accumulation. A single-slice geometry needs no
  // accumulator: the one slice computed is the whole word.
  // ---------------------------------------------------------------------
  if (NSLICE == 1) begin : g_single
    assign a_sel    = a_q;
    assign b_sel    = b_q;
    assign acc_full = y_slice;
  end else begin : g_multi
    logic [NSLICE-1:0][SLICE-1:0] a_s, b_s, acc_q, acc_d;

    assign a_s   = a_q;
    assign b_s   = b_q;
    assign a_sel = a_s[cnt_q];
    assign b_sel = b_s[cnt_q];

    always_comb begin
      acc_d        = acc_q;
      acc_d[cnt_q] = y_slice;
    end

    assign acc_full = acc_d;

    always_ff @(posedge clk) begin
      if (reset)     acc_q <= '0;
      else if (step) acc_q <= acc_d;
    end
  end

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (a_sel),
    .b  (b_sel),
    .op (op_q),
    .y  (y_slice)
  );

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NOT;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        cnt_q <= '0;
      end
      if (step) begin
        if (finish) begin
          // cnt stays at the last slice index; it is cleared on the next accept.
          result_q <= acc_full;
          zero_q   <= (acc_full == '0);
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// ---------------------------------------------------------------------------
// tb_bitwise_logic_seq
//   Self-checking bench for bitwise_logic_seq: default 32/8 instance plus
//   64/64 and 16/4 instances for the geometry corners. A whole-word
//   reference function predicts results; a scoreboard queue pairs each
//   accepted start with the next done pulse of the 32-bit instance.
// ---------------------------------------------------------------------------
module tb_bitwise_logic_seq;
  import alu_logic_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- default instance (32/8) ----------------
  logic              start;
  logic [2:0]        op;
  logic [31:0]       a, b;
  logic              busy, done, zero;
  logic [31:0]       result;
  state_t            st32;

  bitwise_logic_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .dbg_state(st32)
  );

  // ---------------- 64/64 instance ----------------
  logic              start64;
  logic [2:0]        op64;
  logic [63:0]       a64, b64;
  logic              busy64, done64, zero64;
  logic [63:0]       result64;
  state_t            st64;

  bitwise_logic_seq #(.WIDTH(64), .SLICE(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .op(op64), .a(a64), .b(b64),
    .busy(busy64), .done(done64), .result(result64), .zero(zero64), .dbg_state(st64)
  );

  // ---------------- 16/4 instance ----------------
  logic              start16;
  logic [2:0]        op16;
  logic [15:0]       a16, b16;
  logic              busy16, done16, zero16;
  logic [15:0]       result16;
  state_t            st16;

  bitwise_logic_seq #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .zero(zero16), .dbg_state(st16)
  );

  // ---------------- bookkeeping ----------------
  int tests  = 0;
  int failed = 0;
  int done_seen = 0;
  logic [31:0] exp_q[$];

  // Whole-word reference: the op applied to full operands, trimmed to w bits.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] x,
                                        input logic [63:0] y, input int w);
    logic [63:0] r;
    logic [63:0] mask;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    case (o)
      3'd0: r = ~x;
      3'd1: r = x & y;
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: r = ~(x | y);
      3'd5: r = ~(x & y);
      3'd6: r = ~(x ^ y);
      default: r = x;
    endcase
    return r & mask;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor (32-bit instance) ----------------
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("result", 64'(result), 64'(e));
        check("zero", 64'(zero), 64'(e == 32'd0));
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one operation from IDLE and measures cycles from the accepting
  // edge to the done pulse; result/zero are checked by the monitor.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    @(negedge clk);
    check("idle_before_start", 64'(busy), 64'd0);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, 64'(x), 64'(y), 32)[31:0]);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    check("busy_low_with_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_single_pulse", 64'(done), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int d0;
    int n_acc;
    int guard;
    int lat;
    logic [2:0]  ops4 [4];
    logic [31:0] exp4 [4];

    reset = 1'b1;
    start = 0; op = 0; a = 0; b = 0;
    start64 = 0; op64 = 0; a64 = 0; b64 = 0;
    start16 = 0; op16 = 0; a16 = 0; b16 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values and quiet idle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_zero", 64'(zero), 64'd1);
    end

    // NOT.
    run_op(OP_NOT, 32'h0F0F_00FF, 32'h0);
    check("not_value", 64'(result), 64'hF0F0_FF00);
    check("not_zero", 64'(zero), 64'd0);

    // Binary ops on a common pattern.
    ops4[0] = OP_AND;  exp4[0] = 32'hFF00_0000;
    ops4[1] = OP_XOR;  exp4[1] = 32'h00FF_FF00;
    ops4[2] = OP_NOR;  exp4[2] = 32'h0000_00FF;
    ops4[3] = OP_XNOR; exp4[3] = 32'hFF00_00FF;
    for (int i = 0; i < 4; i++) begin
      run_op(ops4[i], 32'hFFFF_0000, 32'hFF00_FF00);
      check("pattern_value", 64'(result), 64'(exp4[i]));
    end

    // XOR of equal operands.
    run_op(OP_XOR, 32'h1234_5678, 32'h1234_5678);
    check("xor_eq_value", 64'(result), 64'd0);
    check("xor_eq_zero", 64'(zero), 64'd1);

    // Random operations.
    for (int i = 0; i < 16; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    // Disturbance while busy: inputs and start wiggle, one done expected.
    d0 = done_seen;
    @(negedge clk);
    op = OP_OR; a = 32'h8001_0400; b = 32'h0220_0010; start = 1'b1;
    exp_q.push_back(32'h8221_0410);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("disturb_busy", 64'(busy), 64'd1);
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      start = (i % 2 == 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("disturb_done_count", 64'(done_seen - d0), 64'd1);
    check("disturb_queue_empty", 64'(exp_q.size()), 64'd0);

    // Back-to-back with start held: new operands presented whenever idle.
    d0 = done_seen;
    n_acc = 0;
    guard = 0;
    while (n_acc < 4 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (!busy) begin
        op = 3'($urandom_range(0, 6));
        a = $urandom | 32'h1;
        b = $urandom;
        start = 1'b1;
        exp_q.push_back(model(op, 64'(a), 64'(b), 32)[31:0]);
        n_acc++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("b2b_done_count", 64'(done_seen - d0), 64'd4);
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset two cycles into RUN: aborted, result cleared, no done.
    run_op(OP_PASS, 32'hA5A5_0001, 32'h0);
    @(negedge clk);
    op = OP_OR; a = 32'h1111_1111; b = 32'h2222_2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    d0 = done_seen;
    repeat (6) @(negedge clk);
    check("abort_no_done", 64'(done_seen - d0), 64'd0);
    run_op(OP_NAND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    check("after_abort_value", 64'(result), 64'hFF0F_EDCB);

    // 64/64: single-cycle NAND of all ones.
    @(negedge clk);
    op64 = OP_NAND; a64 = {64{1'b1}}; b64 = {64{1'b1}}; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    lat = 0;
    while (done64 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w64_latency", 64'(lat), 64'd1);
    check("w64_result", result64, 64'd0);
    check("w64_zero", 64'(zero64), 64'd1);

    // 16/4: PASS across four slices.
    @(negedge clk);
    op16 = OP_PASS; a16 = 16'hBEEF; b16 = 16'($urandom); start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w16_latency", 64'(lat), 64'd4);
    check("w16_result", 64'(result16), 64'(model(OP_PASS, 64'hBEEF, 64'(b16), 16)));
    check("w16_zero", 64'(zero16), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
